// File: rtl/evo_xb_info_scan_pkg.sv
// Shared types and CSR bus widths for the EVO_XB_INFO table scanner.
package evo_xb_info_scan_pkg;

  localparam int CSR_AWIDTH = 16;
  localparam int CSR_DWIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_IDX,
    RD_REQ,
    RD_WAIT,
    EMIT,
    DONE,
    ERR
  } scan_state_e;

  function automatic logic [31:0] clamp_count(input logic [31:0] raw, input logic [31:0] cap);
    return (raw > cap) ? cap : raw;
  endfunction

endpackage

// File: rtl/evo_xb_info_scan_if.sv
// Avalon-MM CSR master bus used by the info scanner to index and read EVO_XB_INFO.
interface evo_xb_info_scan_if;
  import evo_xb_info_scan_pkg::*;

  logic [CSR_AWIDTH-1:0] avm_csr_address;
  logic                  avm_csr_read;
  logic                  avm_csr_write;
  logic [CSR_DWIDTH-1:0] avm_csr_writedata;
  logic                  avm_csr_waitrequest;
  logic                  avm_csr_readdatavalid;
  logic [CSR_DWIDTH-1:0] avm_csr_readdata;

  modport master (
    output avm_csr_address, avm_csr_read, avm_csr_write, avm_csr_writedata,
    input  avm_csr_waitrequest, avm_csr_readdatavalid, avm_csr_readdata
  );

  modport slave (
    input  avm_csr_address, avm_csr_read, avm_csr_write, avm_csr_writedata,
    output avm_csr_waitrequest, avm_csr_readdatavalid, avm_csr_readdata
  );

endinterface

// File: rtl/evo_xb_info_scan.sv
// Walks the EVO_XB_INFO table (write index, read value) and streams entries 1..N out.
// Optional read timeout: define EVO_XB_INFO_SCAN_TIMEOUT_EN.
module evo_xb_info_scan
  import evo_xb_info_scan_pkg::*;
#(
  parameter int INFO_ADDR      = 0,
  parameter int MAX_ENTRIES    = 255,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [31:0]        entry_count,
  output logic               info_valid,
  output logic [31:0]        info_index,
  output logic [31:0]        info_data,
  input  logic               info_ready,
  evo_xb_info_scan_if.master avm
);

  localparam logic [CSR_AWIDTH-1:0] ADDR_W  = CSR_AWIDTH'(INFO_ADDR);
  localparam logic [31:0]           MAX_CAP = 32'(MAX_ENTRIES);

  scan_state_e           state_q;
  logic [31:0]           idx_q;
  logic                  busy_q;
  logic                  done_q;
  logic [31:0]           entry_count_q;
  logic                  info_valid_q;
  logic [31:0]           info_index_q;
  logic [31:0]           info_data_q;
  logic                  write_q;
  logic                  read_q;
  logic [CSR_AWIDTH-1:0] address_q;
  logic [CSR_DWIDTH-1:0] writedata_q;
  logic [31:0]           count_clamped;

  assign count_clamped = clamp_count(avm.avm_csr_readdata, MAX_CAP);

`ifdef EVO_XB_INFO_SCAN_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             error_q;
  assign error = error_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      entry_count_q <= '0;
      info_valid_q  <= 1'b0;
      info_index_q  <= '0;
      info_data_q   <= '0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      address_q     <= '0;
      writedata_q   <= '0;
`ifdef EVO_XB_INFO_SCAN_TIMEOUT_EN
      tmo_q         <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q       <= '0;
            busy_q      <= 1'b1;
            write_q     <= 1'b1;
            address_q   <= ADDR_W;
            writedata_q <= '0;
`ifdef EVO_XB_INFO_SCAN_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
            state_q     <= WR_IDX;
          end
        end
        WR_IDX: begin
          if (!avm.avm_csr_waitrequest) begin
            write_q     <= 1'b0;
            writedata_q <= '0;
            read_q      <= 1'b1;
            state_q     <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (!avm.avm_csr_waitrequest) begin
            read_q    <= 1'b0;
            address_q <= '0;
`ifdef EVO_XB_INFO_SCAN_TIMEOUT_EN
            tmo_q     <= '0;
`endif
            state_q   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (avm.avm_csr_readdatavalid) begin
            if (idx_q == '0) begin
              // Index 0 holds the table size; the clamp keeps idx from ever wrapping.
              entry_count_q <= count_clamped;
              if (count_clamped == '0) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                idx_q       <= 32'd1;
                write_q     <= 1'b1;
                address_q   <= ADDR_W;
                writedata_q <= CSR_DWIDTH'(1);
                state_q     <= WR_IDX;
              end
            end else begin
              info_valid_q <= 1'b1;
              info_index_q <= idx_q;
              info_data_q  <= avm.avm_csr_readdata;
              state_q      <= EMIT;
            end
          end
`ifdef EVO_XB_INFO_SCAN_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ERR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        EMIT: begin
          if (info_ready) begin
            info_valid_q <= 1'b0;
            if (idx_q == entry_count_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q       <= idx_q + 32'd1;
              write_q     <= 1'b1;
              address_q   <= ADDR_W;
              writedata_q <= idx_q + 32'd1;
              state_q     <= WR_IDX;
            end
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign entry_count           = entry_count_q;
  assign info_valid            = info_valid_q;
  assign info_index            = info_index_q;
  assign info_data             = info_data_q;
  assign avm.avm_csr_write     = write_q;
  assign avm.avm_csr_read      = read_q;
  assign avm.avm_csr_address   = address_q;
  assign avm.avm_csr_writedata = writedata_q;

endmodule
